// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_pkg
// Brief  : Shared geometry, refill FSM encoding and address helpers for the cache.
// Rev    : 1.0
// ============================================================================
package cache_pkg;

    localparam int DEF_BLOCK_SIZE             = 32;
    localparam int DEF_NUM_OF_BLOCKS_PER_LINE = 4;
    localparam int DEF_NUM_OF_CACHE_LINES     = 4;
    localparam int DEF_ADDRESS_SIZE           = 32;

    localparam int OFF_W  = $clog2(DEF_NUM_OF_BLOCKS_PER_LINE);
    localparam int IDX_W  = $clog2(DEF_NUM_OF_CACHE_LINES);
    localparam int TAG_W  = DEF_ADDRESS_SIZE - OFF_W - IDX_W;
    localparam int LINE_W = DEF_NUM_OF_BLOCKS_PER_LINE * DEF_BLOCK_SIZE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    typedef logic [LINE_W-1:0] line_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [DEF_ADDRESS_SIZE-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_assembler.sv
`default_nettype none
// ============================================================================
// Module : cache_line_assembler
// Brief  : Counts in-order memory responses and drops each block into its line slot.
// Rev    : 1.0
// ============================================================================
module cache_line_assembler #(
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                capture,
    input  logic [BLOCK_SIZE-1:0]               rsp_data,
    output logic [$clog2(NUM_BLOCKS):0]         rsp_cnt,
    output logic [NUM_BLOCKS*BLOCK_SIZE-1:0]    line
);

    localparam int CNT_W = $clog2(NUM_BLOCKS) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BLOCKS);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt <= '0;
            line    <= '0;
        end else if (clear) begin
            rsp_cnt <= '0;
        end else if (capture && (rsp_cnt != FULL_CNT)) begin
            // Responses past a full line are dropped by the guard above.
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (rsp_cnt == CNT_W'(i)) begin
                    line[i*BLOCK_SIZE +: BLOCK_SIZE] <= rsp_data;
                end
            end
            rsp_cnt <= rsp_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_line_refill.sv
`default_nettype none
// ============================================================================
// Module : cache_line_refill
// Brief  : Fetches a missing line block-by-block from memory and fills the cache once.
// Rev    : 1.0
// ============================================================================
module cache_line_refill
    import cache_pkg::*;
#(
    parameter int BLOCK_SIZE             = cache_pkg::DEF_BLOCK_SIZE,
    parameter int NUM_OF_BLOCKS_PER_LINE = cache_pkg::DEF_NUM_OF_BLOCKS_PER_LINE,
    parameter int NUM_OF_CACHE_LINES     = cache_pkg::DEF_NUM_OF_CACHE_LINES,
    parameter int ADDRESS_SIZE           = cache_pkg::DEF_ADDRESS_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_SIZE-1:0]  miss_addr,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDRESS_SIZE-1:0]  mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [BLOCK_SIZE-1:0]    mem_rsp_data,
    output logic                     fill_valid,
    output logic [$clog2(NUM_OF_CACHE_LINES)-1:0] fill_index,
    output logic [ADDRESS_SIZE-$clog2(NUM_OF_BLOCKS_PER_LINE)-$clog2(NUM_OF_CACHE_LINES)-1:0] fill_tag,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] fill_data,
    output logic                     busy
);

    localparam int BLK_OFF_W  = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int LINE_IDX_W = $clog2(NUM_OF_CACHE_LINES);
    localparam int LINE_TAG_W = ADDRESS_SIZE - BLK_OFF_W - LINE_IDX_W;
    localparam int CNT_W      = BLK_OFF_W + 1;
    localparam logic [CNT_W-1:0] LAST_REQ   = CNT_W'(NUM_OF_BLOCKS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] ALL_BLOCKS = CNT_W'(NUM_OF_BLOCKS_PER_LINE);

    logic [1:0]            state;
    logic [CNT_W-1:0]      req_cnt;
    logic [CNT_W-1:0]      rsp_cnt;
    logic [LINE_IDX_W-1:0] line_index;
    logic [LINE_TAG_W-1:0] line_tag;
    logic                  accept;
    logic                  req_fire;
    logic                  capture;
    logic                  unused_bits;

    assign miss_ready    = (state == ST_IDLE);
    assign busy          = !miss_ready;
    assign accept        = miss_valid && miss_ready;
    assign mem_req_valid = (state == ST_REQ);
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign capture       = mem_rsp_valid && ((state == ST_REQ) || (state == ST_WAIT));
    assign mem_req_addr  = {line_tag, line_index, req_cnt[BLK_OFF_W-1:0]};
    assign fill_valid    = (state == ST_FILL);
    assign fill_index    = line_index;
    assign fill_tag      = line_tag;

    // The miss offset is irrelevant: the whole line is always fetched from block 0.
    assign unused_bits = &{1'b0, miss_addr[BLK_OFF_W-1:0], req_cnt[BLK_OFF_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_cnt    <= '0;
            line_index <= '0;
            line_tag   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        line_tag   <= miss_addr[ADDRESS_SIZE-1 -: LINE_TAG_W];
                        line_index <= miss_addr[BLK_OFF_W +: LINE_IDX_W];
                        req_cnt    <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_fire) begin
                        req_cnt <= req_cnt + 1'b1;
                        if (req_cnt == LAST_REQ) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rsp_cnt == ALL_BLOCKS) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    cache_line_assembler #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_OF_BLOCKS_PER_LINE)
    ) u_assembler (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .capture  (capture),
        .rsp_data (mem_rsp_data),
        .rsp_cnt  (rsp_cnt),
        .line     (fill_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_line_refill
// Brief  : Directed vector table plus reset / idle-response sequences for the refill block.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cache_line_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         fill_valid;
    logic [1:0]   fill_index;
    logic [27:0]  fill_tag;
    logic [127:0] fill_data;
    logic         busy;

    always #5 clk = ~clk;

    cache_line_refill dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .fill_data     (fill_data),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] addr;
        bit          l0;
        int          stall;
        logic [1:0]  idx;
        logic [27:0] tag;
        int          lat;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           lat0 = 1'b0;
    bit           pend_v = 1'b0;
    logic [31:0]  pend_d = '0;
    int           inject = 0;
    int           stall_left = 0;
    logic [31:0]  stall_addr = '0;
    logic [31:0]  req_log[$];
    int           fills = 0;
    int           fill_cyc = 0;
    int           rsp_given = 0;
    logic [1:0]   f_idx = '0;
    logic [27:0]  f_tag = '0;
    logic [127:0] f_data = '0;
    vec_t         vecs[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: memory model drives its inputs, observations are taken, then the edge.
    task automatic tick();
        logic hs;
        mem_req_ready = 1'b1;
        if (stall_left > 0 && mem_req_valid && req_log.size() == 1) begin
            mem_req_ready = 1'b0;
            stall_left--;
            chk("stall_addr_held", mem_req_addr, stall_addr);
        end
        hs = mem_req_valid && mem_req_ready;
        if (inject > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_BEEF;
            inject--;
        end else if (lat0) begin
            mem_rsp_valid = hs;
            mem_rsp_data  = mem_word(mem_req_addr);
        end else begin
            mem_rsp_valid = pend_v;
            mem_rsp_data  = pend_d;
        end
        if (mem_rsp_valid) rsp_given++;
        if (hs) req_log.push_back(mem_req_addr);
        if (fill_valid) begin
            fills++;
            fill_cyc = cyc;
            f_idx    = fill_index;
            f_tag    = fill_tag;
            f_data   = fill_data;
        end
        pend_v = hs;
        pend_d = mem_word(mem_req_addr);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_miss(input string nm, input logic [31:0] addr, input bit l0, input int stall,
                            input logic [1:0] e_idx, input logic [27:0] e_tag, input int e_lat);
        logic [31:0]  base;
        logic [127:0] e_data;
        int           acc;
        int           n;
        bit           bad;
        base = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++) e_data[i*32 +: 32] = mem_word(base + 32'(i));
        req_log.delete();
        fills      = 0;
        lat0       = l0;
        stall_left = stall;
        stall_addr = base + 32'd1;
        n = 0;
        while (!miss_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_ready_at_accept"}, miss_ready, 1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        acc        = cyc;
        tick();
        miss_valid = 1'b0;
        miss_addr  = 32'h5555_5555;
        bad = 1'b0;
        n   = 0;
        while (fills == 0 && n < 40) begin
            if (miss_ready || !busy) bad = 1'b1;
            tick();
            n++;
        end
        chk({nm, "_busy_during"}, bad, 0);
        chk({nm, "_fill_count"}, fills, 1);
        chk({nm, "_latency"}, fill_cyc - acc, e_lat);
        chk({nm, "_index"}, f_idx, e_idx);
        chk({nm, "_tag"}, f_tag, e_tag);
        chk({nm, "_data"}, f_data, e_data);
        chk({nm, "_req_count"}, req_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_req_addr%0d", nm, i),
                (i < req_log.size()) ? req_log[i] : 32'hXXXX_XXXX, base + 32'(i));
        chk({nm, "_ready_after_fill"}, {miss_ready, fill_valid}, 2'b10);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h0000_0ABC, 1'b0, 0, 2'd3, 28'h00000AB, 7};
        vecs[1] = '{32'h0000_1238, 1'b0, 3, 2'd2, 28'h0000123, 10};
        vecs[2] = '{32'h0000_0007, 1'b1, 0, 2'd1, 28'h0000000, 6};
        vecs[3] = '{32'h0000_0010, 1'b0, 0, 2'd0, 28'h0000001, 7};
        vecs[4] = '{32'h0000_0024, 1'b0, 0, 2'd1, 28'h0000002, 7};
        vecs[5] = '{32'hFFFF_FFFE, 1'b1, 0, 2'd3, 28'hFFFFFFF, 6};

        rst           = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;

        chk("reset_miss_ready", miss_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_req_valid", mem_req_valid, 0);
        chk("reset_fill_valid", fill_valid, 0);
        chk("reset_fill_fields", {fill_index, fill_tag, fill_data}, 0);

        // Responses with no miss pending must be ignored entirely.
        fills  = 0;
        inject = 3;
        repeat (3) tick();
        chk("idle_rsp_state", {miss_ready, busy, mem_req_valid}, 3'b100);
        chk("idle_rsp_no_fill", fills, 0);

        for (int i = 0; i < 6; i++)
            run_miss($sformatf("v%0d", i), vecs[i].addr, vecs[i].l0, vecs[i].stall,
                     vecs[i].idx, vecs[i].tag, vecs[i].lat);

        // Reset in the middle of a miss, after two responses have landed.
        req_log.delete();
        fills      = 0;
        lat0       = 1'b0;
        rsp_given  = 0;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0040;
        tick();
        miss_valid = 1'b0;
        n = 0;
        while (rsp_given < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_two_rsps", rsp_given, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_idle_after", {miss_ready, busy, mem_req_valid}, 3'b100);
        inject = 2;
        repeat (3) tick();
        chk("midrst_no_fill", fills, 0);
        chk("midrst_still_idle", busy, 0);
        run_miss("midrst_recover", 32'h0000_0040, 1'b0, 0, 2'd0, 28'h0000004, 7);

        // Reset wins over a simultaneous miss.
        rst        = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0080;
        tick();
        rst        = 1'b0;
        miss_valid = 1'b0;
        chk("rst_vs_miss_busy", busy, 0);
        tick();
        chk("rst_vs_miss_no_req", {busy, mem_req_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
